// File: rtl/thermo_dec_4_15.sv
// Two-stage valid/ready pipeline decoding a 4-bit ones-count into a 15-bit thermometer word.
// Optional macro THERMO_STATS_EN adds total_ones, a saturating sum of accepted counts.
module thermo_dec_4_15 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_count,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [14:0] out_thermo
`ifdef THERMO_STATS_EN
   ,
   output logic [7:0]  total_ones
`endif
);

   logic        s1_valid_reg;
   logic [3:0]  s1_count_reg;
   logic        s2_valid_reg;
   logic [14:0] s2_thermo_reg;
   logic [14:0] thermo_next;
   logic        in_xfer;
   logic        out_xfer;
   logic        s2_load;

   assign out_xfer   = s2_valid_reg && out_ready;
   assign s2_load    = s1_valid_reg && (!s2_valid_reg || out_xfer);
   // S1 may take a new word in the same cycle its current word moves into S2.
   assign in_ready   = rst_n && (!s1_valid_reg || s2_load);
   assign in_xfer    = in_valid && in_ready;
   assign out_valid  = s2_valid_reg;
   assign out_thermo = s2_thermo_reg;

   generate
      for (genvar gi = 0; gi < 15; gi++) begin : g_decode
         assign thermo_next[gi] = (s1_count_reg > 4'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_reg  <= 1'b0;
         s1_count_reg  <= 4'd0;
         s2_valid_reg  <= 1'b0;
         s2_thermo_reg <= 15'h0000;
      end else begin
         if (in_xfer) begin
            s1_count_reg <= in_count;
            s1_valid_reg <= 1'b1;
         end else if (s2_load) begin
            s1_valid_reg <= 1'b0;
         end

         if (s2_load) begin
            s2_thermo_reg <= thermo_next;
            s2_valid_reg  <= 1'b1;
         end else if (out_xfer) begin
            s2_valid_reg  <= 1'b0;
         end
      end
   end

`ifdef THERMO_STATS_EN
   logic [7:0] total_reg;
   logic [8:0] total_sum;

   assign total_sum  = {1'b0, total_reg} + {5'd0, in_count};
   assign total_ones = total_reg;

   // Carry out of bit 7 means the sum passed 255; clamp and stay there.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         total_reg <= 8'd0;
      end else if (in_xfer) begin
         total_reg <= total_sum[8] ? 8'd255 : total_sum[7:0];
      end
   end
`endif

endmodule

// File: tb/tb_thermo_dec_4_15.sv
// Scoreboard bench for thermo_dec_4_15: directed scenarios plus randomized valid/ready traffic.
module tb_thermo_dec_4_15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_count;
   logic        out_valid;
   logic        out_ready;
   logic [14:0] out_thermo;
`ifdef THERMO_STATS_EN
   logic [7:0]  total_ones;
`endif

   thermo_dec_4_15 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_count   (in_count),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_thermo (out_thermo)
`ifdef THERMO_STATS_EN
      ,
      .total_ones (total_ones)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  count;
      logic [14:0] thermo;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   bit   lat_chk = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [14:0] model_thermo(input int n);
      return 15'((32'd1 << n) - 32'd1);
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Input side: every accepted count pushes its expected word.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n === 1'b1 && in_valid && in_ready === 1'b1) begin
         e.count  = in_count;
         e.thermo = model_thermo(int'(in_count));
         e.cyc    = cyc;
         exp_q.push_back(e);
      end
   end

   // Output side: pop and compare on every output transfer; also check hold under stall.
   initial begin
      bit          prev_stall = 1'b0;
      logic [14:0] prev_thermo = 15'h0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (prev_stall) begin
               check("hold_valid", out_valid, 1'b1);
               check("hold_data", out_thermo, prev_thermo);
            end
            if (out_valid === 1'b1 && out_ready) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL spurious_output: got %0h with nothing expected at cycle %0d", out_thermo, cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("thermo", out_thermo, e.thermo);
                  check("popcount", $countones(out_thermo), e.count);
                  if (lat_chk) check("latency", cyc - e.cyc, 2);
                  $display("[TB] out count=%0d thermo=%04h", e.count, out_thermo);
               end
            end
            prev_stall  = (out_valid === 1'b1) && !out_ready;
            prev_thermo = out_thermo;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   // All tasks start and end at posedge+1.
   task automatic send(input logic [3:0] n);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_count = n;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: got no in_ready required 1 for count %0d", n);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      check("drain_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("rst_in_ready_low", in_ready, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_thermo", out_thermo, 15'h0000);
      check("rst_in_ready_high", in_ready, 1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      bit acc;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_count  = 4'd0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Sweep all 16 counts back-to-back at full rate.
      out_ready = 1'b1;
      lat_chk   = 1'b1;
      for (int n = 0; n < 16; n++) send(4'(n));
      drain();
      lat_chk   = 1'b0;

      // Backpressure: third word must stall while the first holds at the output.
      out_ready = 1'b0;
      send(4'd5);
      send(4'd9);
      in_valid = 1'b1;
      in_count = 4'd12;
      repeat (3) begin
         @(negedge clk);
         check("full_in_ready", in_ready, 1'b0);
         check("full_out_valid", out_valid, 1'b1);
         check("full_out_thermo", out_thermo, 15'h001F);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(4'd12);
      drain();

      // Mid-stream reset discards both in-flight words.
      out_ready = 1'b0;
      send(4'd7);
      send(4'd3);
      do_reset();
      out_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("post_rst_no_output", out_valid, 1'b0);
      end
      @(posedge clk);
      #1;

      // Both stages full then streaming: no bubble.
      out_ready = 1'b0;
      send(4'd10);
      send(4'd10);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_count  = 4'd10;
      repeat (20) begin
         @(negedge clk);
         check("stream_in_ready", in_ready, 1'b1);
         check("stream_out_valid", out_valid, 1'b1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();

      // Random traffic, 50% in_valid and 50% out_ready.
      sent = 0;
      for (int c = 0; c < 20000 && sent < 1000; c++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (!in_valid && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b1;
            in_count = 4'($urandom_range(0, 15));
         end
         @(negedge clk);
         acc = in_valid && (in_ready === 1'b1);
         @(posedge clk);
         #1;
         if (acc) begin
            in_valid = 1'b0;
            sent++;
         end
      end
      check("random_sent", sent, 1000);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

`ifdef THERMO_STATS_EN
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 18; i++) begin
         send(4'd15);
         check("total_ones", total_ones, (i * 15 > 255) ? 255 : i * 15);
      end
      drain();
      do_reset();
      check("total_ones_reset", total_ones, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/thermo_dec_4_15.md
THERMO_DEC_4_15 -- requirements
Module: thermo_dec_4_15

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  in_count is valid this cycle.
REQ-005 in_ready  output  1  block accepts in_count this cycle.
REQ-006 in_count  input  4  binary ones-count, 0..15.
REQ-007 out_valid  output  1  out_thermo is valid this cycle.
REQ-008 out_ready  input  1  downstream accepts out_thermo this cycle.
REQ-009 out_thermo  output  15  thermometer code: bits [n-1:0]=1, bits [14:n]=0 for count n.
REQ-010 total_ones  output  8  present only with THERMO_STATS_EN; saturating sum of accepted counts.

Function
REQ-011 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-012 The datapath SHALL be a two-stage register pipeline: S1 holds the accepted count, S2 holds the decoded 15-bit thermometer word.
REQ-013 Each stage SHALL load when it is empty or its downstream transfers in the same cycle; S1 SHALL be able to advance when S2 transfers out in that same cycle.
REQ-014 in_ready SHALL equal (!S1_valid || S2 loads this cycle), computed combinationally from out_ready.
REQ-015 Latency SHALL be exactly 2 cycles from input transfer to out_valid=1 with out_ready held 1; throughput SHALL be one word per cycle.
REQ-016 Output order SHALL equal input order; no word SHALL be dropped or duplicated under any out_ready pattern.
REQ-017 While out_valid=1 and out_ready=0, out_thermo SHALL remain stable.
REQ-018 Decode SHALL satisfy popcount(out_thermo)=in_count for all 16 codes; count 0 -> 15'h0000, count 15 -> 15'h7FFF.
REQ-019 With both stages full and out_ready=0, in_ready SHALL be 0 and in_count SHALL be ignored.
REQ-020 Simultaneous input and output transfers with both stages full SHALL shift the pipeline with no bubble.

Reset
REQ-021 While rst_n=0 at a clock edge, S1_valid and S2_valid SHALL clear; out_valid SHALL be 0 and out_thermo SHALL be 15'h0000 the following cycle.
REQ-022 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after reset release.
REQ-023 Reset asserted mid-stream SHALL discard all in-flight words; no output transfer SHALL occur for them after reset.
REQ-024 total_ones (when present) SHALL reset to 8'd0.

Configuration
REQ-025 With macro THERMO_STATS_EN defined, the block SHALL include total_ones: on each input transfer it SHALL add in_count, saturating at 8'd255 and holding there until reset.
REQ-026 Without THERMO_STATS_EN, port total_ones and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 Reset then in_count=0..15 back-to-back, out_ready=1 -> out_valid on cycles 2..17, out_thermo = 15'h0000, 15'h0001, 15'h0003, ... 15'h7FFF in order.
REQ-028 Inputs 5, 9, 12 with out_ready=0 -> in_ready falls to 0 after two accepts; out_thermo holds 15'h001F; on out_ready=1 the outputs are 15'h001F, 15'h01FF, 15'h0FFF with no loss.
REQ-029 Random in_valid/out_ready at 50% each, 1000 words -> scoreboard matches order, and popcount(out_thermo) equals each sent count.
REQ-030 Fill pipeline with 7 and 3, assert rst_n=0 one cycle -> next cycle out_valid=0, out_thermo=15'h0000, in_ready=1 after release; neither word appears.
REQ-031 THERMO_STATS_EN: send 17 words of count 15 -> total_ones=255 after the 17th (255 exactly), stays 255 after an 18th; reset -> 0.
REQ-032 Both stages full, out_ready=1 and in_valid=1 continuously with count 10 -> one output per cycle, each 15'h03FF, in_ready constantly 1.
